// File: rtl/z180_bus_pkg.sv
// rtl/z180_bus_pkg.sv - shared Z180 bus-cycle state, direction and edge-counter definitions
package z180_bus_pkg;

    localparam int EDGE_CNT_W   = 4;
    localparam int EDGE_CNT_MAX = (1 << EDGE_CNT_W) - 1;

    typedef logic [1:0] bus_state_t;

    localparam bus_state_t ST_IDLE  = 2'd0;
    localparam bus_state_t ST_COUNT = 2'd1;
    localparam bus_state_t ST_DONE  = 2'd2;

    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

    // Limits beyond the counter range collapse onto saturation so they stay reachable.
    function automatic logic [EDGE_CNT_W-1:0] clamp_edge(input int value);
        if (value < 0) begin
            return '0;
        end else if (value > EDGE_CNT_MAX) begin
            return EDGE_CNT_W'(EDGE_CNT_MAX);
        end else begin
            return EDGE_CNT_W'(value);
        end
    endfunction

endpackage

// File: rtl/z180_edge_counter.sv
// rtl/z180_edge_counter.sv - saturating falling-phi edge counter with runtime limit compare
module z180_edge_counter
    import z180_bus_pkg::*;
(
    input  logic                  i_phi,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_en,
    input  logic [EDGE_CNT_W-1:0] i_limit,
    output logic [EDGE_CNT_W-1:0] o_idx,
    output logic                  o_reached
);

    logic [EDGE_CNT_W-1:0] r_count;
    logic [EDGE_CNT_W-1:0] w_inc;

    assign w_inc = (r_count == '1) ? r_count : r_count + 1'b1;

    // o_idx is the index of the edge currently being sampled; a clear makes it edge 0.
    assign o_idx     = i_clear ? '0 : w_inc;
    assign o_reached = (o_idx >= i_limit);

    always_ff @(negedge i_phi or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_idx;
        end
    end

endmodule

// File: rtl/z180_io_window.sv
// rtl/z180_io_window.sv - Z8S180 I/O port-window decode, tick generation and /WAIT control
module z180_io_window
    import z180_bus_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR    = 8'h80,
    parameter int         NPORT_LOG2   = 1,
    parameter int         RD_TICK_EDGE = 0,
    parameter int         WR_TICK_EDGE = 1,
    parameter int         WAIT_STATES  = 0,
    parameter int         WAIT_MAX     = 15
) (
    input  logic                                          phi,
    input  logic                                          reset,
    input  logic                                          iorq_n,
    input  logic                                          rd_n,
    input  logic                                          wr_n,
    input  logic [7:0]                                    a,
    input  logic [7:0]                                    d_in,
    input  logic [7:0]                                    client_rd_data,
    input  logic                                          client_ready,
    output logic [((NPORT_LOG2 > 0) ? NPORT_LOG2 : 1)-1:0] port_idx,
    output logic                                          rd_tick,
    output logic                                          wr_tick,
    output logic [7:0]                                    wr_data,
    output logic                                          dbus_out,
    output logic [7:0]                                    dout,
    output logic                                          wait_n,
    output logic                                          timeout
);

    localparam int PW = (NPORT_LOG2 > 0) ? NPORT_LOG2 : 1;

    localparam logic [EDGE_CNT_W-1:0] RD_MIN = clamp_edge(
        (RD_TICK_EDGE > WAIT_STATES) ? RD_TICK_EDGE : WAIT_STATES);
    localparam logic [EDGE_CNT_W-1:0] WR_MIN = clamp_edge(
        (WR_TICK_EDGE > WAIT_STATES) ? WR_TICK_EDGE : WAIT_STATES);
    localparam logic [EDGE_CNT_W-1:0] WS_LIM = clamp_edge(WAIT_STATES);
    localparam logic [EDGE_CNT_W-1:0] TO_LIM = clamp_edge(WAIT_STATES + WAIT_MAX);

    bus_state_t      r_state;
    logic            r_dir;
    logic [PW-1:0]   r_port_idx;
    logic            r_rd_tick;
    logic            r_wr_tick;
    logic [7:0]      r_wr_data;
    logic            r_wait_n;
    logic            r_timeout;

    logic            w_strobe;
    logic            w_addr_hit;
    logic            w_hit;
    logic            w_dir_now;
    logic            w_dir;
    logic            w_idle;
    logic            w_cnt_en;
    logic [PW-1:0]   w_port_sel;
    logic [EDGE_CNT_W-1:0] w_limit;
    logic [EDGE_CNT_W-1:0] w_idx;
    logic            w_min_ok;
    logic            w_ws_done;
    logic            w_to_reached;
    logic            w_release;
    logic            w_wait_ok;

    assign w_strobe   = ~rd_n | ~wr_n;
    assign w_addr_hit = ((a >> NPORT_LOG2) == (BASE_ADDR >> NPORT_LOG2));
    assign w_hit      = ~iorq_n & w_strobe & w_addr_hit;
    assign w_port_sel = (NPORT_LOG2 == 0) ? '0 : a[PW-1:0];

    // Read wins when both strobes are low.
    assign w_dir_now  = ~rd_n ? DIR_RD : DIR_WR;
    assign w_idle     = (r_state == ST_IDLE);
    assign w_dir      = w_idle ? w_dir_now : r_dir;
    assign w_limit    = (w_dir == DIR_RD) ? RD_MIN : WR_MIN;
    assign w_cnt_en   = (w_idle & w_hit) | (r_state == ST_COUNT);

    z180_edge_counter u_edge_counter (
        .i_phi     (phi),
        .i_rst     (reset),
        .i_clear   (w_idle),
        .i_en      (w_cnt_en),
        .i_limit   (w_limit),
        .o_idx     (w_idx),
        .o_reached (w_min_ok)
    );

    assign w_ws_done    = (w_idx >= WS_LIM);
    assign w_to_reached = (w_idx >= TO_LIM);
    assign w_release    = w_min_ok & (client_ready | w_to_reached);
    assign w_wait_ok    = w_ws_done & client_ready;

    always_ff @(negedge phi or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_dir      <= DIR_WR;
            r_port_idx <= '0;
            r_rd_tick  <= 1'b0;
            r_wr_tick  <= 1'b0;
            r_wr_data  <= 8'h00;
            r_wait_n   <= 1'b1;
            r_timeout  <= 1'b0;
        end else begin
            r_rd_tick <= 1'b0;
            r_wr_tick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wait_n <= 1'b1;
                    if (w_hit) begin
                        r_port_idx <= w_port_sel;
                        r_dir      <= w_dir_now;
                        if (w_release) begin
                            if (w_dir_now == DIR_RD) begin
                                r_rd_tick <= 1'b1;
                            end else begin
                                r_wr_tick <= 1'b1;
                                r_wr_data <= d_in;
                            end
                            if (!client_ready) begin
                                r_timeout <= 1'b1;
                            end
                            r_state <= ST_DONE;
                        end else begin
                            r_wait_n <= w_wait_ok;
                            r_state  <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    if (iorq_n) begin
                        r_wait_n <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else if (w_release) begin
                        if (r_dir == DIR_RD) begin
                            r_rd_tick <= 1'b1;
                        end else begin
                            r_wr_tick <= 1'b1;
                            r_wr_data <= d_in;
                        end
                        if (!client_ready) begin
                            r_timeout <= 1'b1;
                        end
                        r_wait_n <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_wait_n <= w_wait_ok;
                    end
                end
                ST_DONE: begin
                    r_wait_n <= 1'b1;
                    if (iorq_n | (rd_n & wr_n)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_wait_n <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign port_idx = r_port_idx;
    assign rd_tick  = r_rd_tick;
    assign wr_tick  = r_wr_tick;
    assign wr_data  = r_wr_data;
    assign wait_n   = r_wait_n;
    assign timeout  = r_timeout;
    assign dbus_out = ~iorq_n & ~rd_n & w_hit;
    assign dout     = client_rd_data;

endmodule

// File: doc/z180_io_window.md
Name: z180_io_window

Overview:
- Parametrised Z8S180 I/O-cycle engine that replaces the per-port decode wires and the separate fixed rd/wr tick FSMs in the top level.
- Decodes a window of 2^NPORT_LOG2 consecutive I/O ports at BASE_ADDR and issues one phi-synchronous read or write tick per CPU I/O cycle, at a programmable edge.
- Inserts programmable wait states, and holds /WAIT while a client is not ready, with a timeout.
- Sits between the CPU bus pins and I/O clients such as the VDP, joystick and GPIO ports.

Parameters:
- BASE_ADDR, 8'h80: first port of window; low NPORT_LOG2 bits must be 0.
- NPORT_LOG2, 1: window size is 2^NPORT_LOG2 ports (0..4).
- RD_TICK_EDGE, 0: falling-phi edge index (from cycle start) at which rd_tick fires, minimum.
- WR_TICK_EDGE, 1: falling-phi edge index at which wr_tick fires, minimum.
- WAIT_STATES, 0: fixed wait states inserted per window cycle (0..7).
- WAIT_MAX, 15: maximum extra edges /WAIT is held for a not-ready client before timeout.

Ports:
- phi  in  1  CPU PHI clock; all state updates on falling edge.
- reset  in  1  asynchronous, active-high.
- iorq_n  in  1  CPU /IORQ.
- rd_n  in  1  CPU /RD.
- wr_n  in  1  CPU /WR.
- a  in  8  CPU A[7:0].
- d_in  in  8  CPU data bus, input side.
- client_rd_data  in  8  data for the selected port.
- client_ready  in  1  client can complete the current cycle.
- port_idx  out  NPORT_LOG2 (min 1)  a[NPORT_LOG2-1:0], registered at cycle start.
- rd_tick  out  1  one-phi pulse: read completes.
- wr_tick  out  1  one-phi pulse: write completes.
- wr_data  out  8  d_in captured on the wr_tick edge.
- dbus_out  out  1  async: window read in progress; top level drives d.
- dout  out  8  async passthrough of client_rd_data.
- wait_n  out  1  CPU /WAIT, registered.
- timeout  out  1  sticky; set on client timeout, cleared by reset only.

Behaviour:
- Hit: iorq_n=0 && (rd_n=0 || wr_n=0) && a[7:NPORT_LOG2]==BASE_ADDR[7:NPORT_LOG2]. Sampled on falling phi.
- dbus_out = ~iorq_n & ~rd_n & hit, combinational. dout = client_rd_data.
- Reset values: state IDLE, rd_tick=0, wr_tick=0, wait_n=1, timeout=0, wr_data=0, port_idx=0, edge counter=0.
- IDLE:
  - On a hit edge, latch port_idx and the direction (rd wins if both rd_n and wr_n are low).
  - Clear the counter to 0.
  - Drive wait_n=0 if WAIT_STATES>0 or client_ready=0.
  - Go to COUNT. This edge is edge 0.
- COUNT: each falling edge, counter+1 (saturating 4 bits). The cycle is released at the first edge where all of the following hold:
  - counter >= TICK_EDGE for the latched direction;
  - counter >= WAIT_STATES;
  - client_ready=1, or counter >= WAIT_STATES+WAIT_MAX.
- Release edge:
  - Pulse rd_tick or wr_tick high for exactly that phi period.
  - For a write, capture wr_data <= d_in.
  - Set wait_n=1.
  - If released by WAIT_MAX with client_ready=0: set timeout and still pulse the tick.
  - Go to DONE.
- RD_TICK_EDGE=0 with WAIT_STATES=0 and client ready: rd_tick fires on edge 0 itself, with wait_n never asserted. IDLE goes directly to DONE.
- DONE: stay until a falling edge samples iorq_n=1 or (rd_n=1 && wr_n=1), then go to IDLE. Only one tick per CPU cycle.
- Abort: iorq_n sampled 1 in COUNT → IDLE, no tick, wait_n=1.
- Back-to-back cycles: a new hit is recognised only from IDLE. The minimum gap is one edge with strobes inactive, which the Z180 guarantees.
- Asynchronous reset mid-cycle:
  - Outputs return to reset values immediately, including wait_n=1.
  - An in-flight tick is lost.

Decomposition:
- Shared package z180_bus_pkg: state enum (IDLE, COUNT, DONE), direction constants, edge-counter width localparam (4).
- One natural sub-module: z180_edge_counter (saturating counter with compare against a runtime limit), reused by a future memory-window block.
- Decode and FSM live in z180_io_window.

Test Plan:
- Default parameters, OUT (0x81),0x5A with 3-edge /WR → wr_tick on edge 1, port_idx=1, wr_data=0x5A, wait_n stays 1.
- IN from 0x80, client_ready=1, client_rd_data=0xC3 → dbus_out high for the strobe duration, dout=0xC3, rd_tick on edge 0, exactly one pulse.
- WAIT_STATES=2, write to 0x80 → wait_n low from edge 0, released at edge 2, wr_tick on edge 2.
- client_ready=0 for 4 edges, WAIT_MAX=15 → wait_n low edges 0–3, rd_tick on edge 4, timeout=0. With client_ready held 0 → tick on edge 15, timeout=1.
- Access to 0x82 or 0x7F, and a memory cycle with a=0x80 → no ticks, dbus_out=0, wait_n=1.
- Assert reset during a WAIT_STATES=3 cycle at edge 1 → wait_n=1 and no tick. After release, the next OUT (0x80) completes normally.
